// File: rtl/if_fetch_ctrl.sv
// Purpose: instruction-fetch controller; sequences the PC, drives the inst SRAM
//          handshake (one request outstanding) and buffers fetched {inst, pc} toward ID.
// Latency: addr_ok in cycle N, data_ok in cycle M>N, IF_to_ID_valid in cycle M+1.
// Backpressure: ID_allowin pops the buffer head; while the buffer is full no request is issued.
//
// Optional feature: define IF_INST_BUF2_EN for a two-entry instruction buffer so that
// fetching continues while ID is stalled with one entry held; default is one entry.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush, flush_pc     redirect request and its target PC (highest priority)
//   ID_allowin          ID consumes the buffer head this cycle
//   inst_sram_req/addr  fetch request and address (registered)
//   inst_sram_addr_ok   request accepted this cycle
//   inst_sram_data_ok   read data valid this cycle, with inst_sram_rdata
//   IF_to_ID_valid/bus  buffer head valid and {inst[31:0], pc[31:0]}
`timescale 1ns/1ps
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        ID_allowin,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        IF_to_ID_valid,
  output logic [63:0] IF_to_ID_bus
);

`ifdef IF_INST_BUF2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      state;
  logic        req_q;     // registered copy of inst_sram_req
  logic [31:0] pc;        // next address to fetch
  logic [31:0] req_pc;    // address of the outstanding request
  logic        discard;   // outstanding response belongs to a redirected-away path

  // Instruction buffer: ent0 is always the head. Two physical slots exist; with a
  // one-entry configuration occupancy never exceeds one, so ent1 is never loaded.
  logic [1:0]  cnt;
  logic [63:0] ent0;
  logic [63:0] ent1;

  logic        pop;
  logic        push;
  logic [63:0] push_dat;
  logic [1:0]  cnt_after;
  logic [1:0]  wr_idx;
  logic        has_room;

  // ---------------------------------------------------------------------------
  // Buffer control
  // ---------------------------------------------------------------------------
  // A flush empties the buffer and the head is not considered consumed.
  assign pop       = (cnt != 2'd0) && ID_allowin && !flush;
  assign push      = (state == S_WAIT) && inst_sram_data_ok && !discard && !flush;
  assign push_dat  = {inst_sram_rdata, req_pc};
  assign cnt_after = cnt + {1'b0, push} - {1'b0, pop};
  // The pushed entry lands behind whatever survives this cycle's pop.
  assign wr_idx    = cnt - {1'b0, pop};
  // Decides whether the next fetch may be issued right after this cycle's push.
  assign has_room  = (cnt_after < DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= 64'b0;
      ent1 <= 64'b0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_after;
      if (push && (wr_idx == 2'd0)) begin
        ent0 <= push_dat;
      end else if (pop) begin
        ent0 <= ent1;
      end
      if (push && (wr_idx == 2'd1)) begin
        ent1 <= push_dat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      req_q   <= 1'b0;
      pc      <= RESET_PC;
      req_pc  <= RESET_PC;
      discard <= 1'b0;
    end else if (flush) begin
      // Redirect wins over every other event this cycle.
      pc <= flush_pc;
      case (state)
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            // The old address was accepted anyway: wait out its response and drop it.
            req_pc  <= pc;
            discard <= 1'b1;
            state   <= S_WAIT;
            req_q   <= 1'b0;
          end else begin
            // Still requesting; the new address appears on the bus next cycle.
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            // Response arrives together with the flush: nothing left in flight.
            discard <= 1'b0;
            state   <= S_REQ;
            req_q   <= 1'b1;
          end else begin
            discard <= 1'b1;
            state   <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        default: begin
          // S_INIT or S_FULL: nothing outstanding, restart at the target.
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_INIT: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            req_pc <= pc;
            state  <= S_WAIT;
            req_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            if (discard) begin
              // Stale response from before a redirect: pc already holds the target.
              discard <= 1'b0;
              state   <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              pc <= req_pc + 32'd4;
              if (has_room) begin
                state <= S_REQ;
                req_q <= 1'b1;
              end else begin
                state <= S_FULL;
                req_q <= 1'b0;
              end
            end
          end
        end
        S_FULL: begin
          if (pop) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst_sram_req  = req_q;
  assign inst_sram_addr = pc;
  assign IF_to_ID_valid = (cnt != 2'd0);
  assign IF_to_ID_bus   = (cnt != 2'd0) ? ent0 : 64'b0;

endmodule
